// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helpers for the serial transmit sequencer.
// Imported by the interface, the shift-register datapath and the controller.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int WIDTH_MAX = 32;
   localparam int GAP_MAX   = 15;

   // Bits needed to hold the values 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// Producer-facing handshake plus serial-side status of the transmit sequencer.
// The producer uses the master view, the controller the slave view.
interface shift_reg_ctrl_if import shift_reg_pkg::*; #(
   parameter int WIDTH = 8
);

   localparam int IDX_W = cnt_width(WIDTH);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             serial_out;
   logic             frame;
   logic             busy;
   logic             done;
   logic [IDX_W-1:0] bit_idx;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  serial_out,
      input  frame,
      input  busy,
      input  done,
      input  bit_idx
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output serial_out,
      output frame,
      output busy,
      output done,
      output bit_idx
   );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out data register; the serial bit is taken straight from
// the register end that leaves first, so it is a flop output.
module piso_shift_reg import shift_reg_pkg::*; #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   output logic             serial_out
);

   logic [WIDTH-1:0] data_r;
   logic [WIDTH-1:0] data_next_s;

   // Next register value: a load wins over a shift.
   always_comb begin
      data_next_s = data_r;
      if (load) begin
         data_next_s = load_data;
      end else if (shift_en) begin
         if (MSB_FIRST) begin
            data_next_s = {data_r[WIDTH-2:0], 1'b0};
         end else begin
            data_next_s = {1'b0, data_r[WIDTH-1:1]};
         end
      end else begin
         data_next_s = data_r;
      end
   end

   // Data register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= '0;
      end else begin
         data_r <= data_next_s;
      end
   end

   assign serial_out = MSB_FIRST ? data_r[WIDTH-1] : data_r[0];

endmodule

// File: rtl/shift_reg_ctrl.sv
// Transmit sequencer: accepts a word over valid/ready, shifts it out framed,
// then holds the line idle for a programmable gap before the next word.
module shift_reg_ctrl import shift_reg_pkg::*; #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   shift_reg_ctrl_if.slave  bus
);

   localparam int IDX_W = cnt_width(WIDTH);
   localparam int GAP_W = cnt_width(GAP_MAX + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state_r;
   state_t           next_state_s;
   logic [IDX_W-1:0] bit_cnt_r;
   logic [IDX_W-1:0] bit_cnt_next_s;
   logic [GAP_W-1:0] gap_cnt_r;
   logic [GAP_W-1:0] gap_cnt_next_s;
   logic             in_ready_r;
   logic             frame_r;
   logic             busy_r;
   logic             done_r;
   logic             done_next_s;
   logic             accept_s;
   logic             load_s;
   logic             shift_en_s;
   logic             piso_bit_s;

   // in_ready is a flop, so the first cycle after reset release never accepts.
   assign accept_s = bus.in_valid && in_ready_r;

   // Next-state, counter and datapath-control decode.
   always_comb begin
      next_state_s   = state_r;
      bit_cnt_next_s = bit_cnt_r;
      gap_cnt_next_s = gap_cnt_r;
      done_next_s    = 1'b0;
      load_s         = 1'b0;
      shift_en_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               load_s         = 1'b1;
               bit_cnt_next_s = '0;
               next_state_s   = SHIFT;
            end else begin
               next_state_s   = IDLE;
            end
         end
         SHIFT: begin
            shift_en_s = 1'b1;
            if (bit_cnt_r == LAST_IDX) begin
               done_next_s    = 1'b1;
               bit_cnt_next_s = '0;
               if (GAP_CYCLES > 0) begin
                  next_state_s   = GAP;
                  gap_cnt_next_s = GAP_LOAD;
               end else begin
                  next_state_s   = IDLE;
               end
            end else begin
               bit_cnt_next_s = bit_cnt_r + IDX_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt_r == '0) begin
               next_state_s   = IDLE;
            end else begin
               gap_cnt_next_s = gap_cnt_r - GAP_W'(1);
            end
         end
         default: begin
            next_state_s   = IDLE;
            bit_cnt_next_s = '0;
            gap_cnt_next_s = '0;
         end
      endcase
   end

   // State, counters and registered status outputs (derived from the next state).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         bit_cnt_r  <= '0;
         gap_cnt_r  <= '0;
         in_ready_r <= 1'b0;
         frame_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         bit_cnt_r  <= bit_cnt_next_s;
         gap_cnt_r  <= gap_cnt_next_s;
         in_ready_r <= (next_state_s == IDLE);
         frame_r    <= (next_state_s == SHIFT);
         busy_r     <= (next_state_s != IDLE);
         done_r     <= done_next_s;
      end
   end

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s),
      .load_data  (bus.in_data),
      .shift_en   (shift_en_s),
      .serial_out (piso_bit_s)
   );

   // Gating with frame_r makes an asynchronous reset idle the line at once.
   assign bus.serial_out = frame_r ? piso_bit_s : IDLE_LEVEL;
   assign bus.in_ready   = in_ready_r;
   assign bus.frame      = frame_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.bit_idx    = bit_cnt_r;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Randomized bench for two sequencer configurations (MSB-first with a 3-cycle gap,
// LSB-first with no gap) against a timeline model of the transmit schedule.
module tb_shift_reg_ctrl;

   localparam int W  = 8;
   localparam int G0 = 3;
   localparam int G1 = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_s = 1'b0;
   logic [7:0] data_s  = 8'h00;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit track    = 1'b0;
   int hs0_q [$];
   int hs1_q [$];
   logic [7:0] cap0 = 8'h00;
   logic [7:0] cap1 = 8'h00;

   // Model: cycles elapsed since the accepting edge (-1 = in reset, 0 = idle).
   int         phase [2] = '{-1, -1};
   logic [7:0] word  [2] = '{8'h00, 8'h00};

   always #5 clk = ~clk;

   shift_reg_ctrl_if #(.WIDTH(W)) bus0 ();
   shift_reg_ctrl_if #(.WIDTH(W)) bus1 ();

   assign bus0.in_valid = valid_s;
   assign bus0.in_data  = data_s;
   assign bus1.in_valid = valid_s;
   assign bus1.in_data  = data_s;

   shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(G0), .IDLE_LEVEL(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   shift_reg_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(G1), .IDLE_LEVEL(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   wire [7:0] vec0 = {bus0.in_ready, bus0.frame, bus0.busy, bus0.done, bus0.serial_out, bus0.bit_idx};
   wire [7:0] vec1 = {bus1.in_ready, bus1.frame, bus1.busy, bus1.done, bus1.serial_out, bus1.bit_idx};

   function automatic int gap_of(input int u);
      return (u == 0) ? G0 : G1;
   endfunction

   function automatic logic lvl_of(input int u);
      return (u == 0) ? 1'b0 : 1'b1;
   endfunction

   function automatic bit exp_ready(input int u);
      return (phase[u] == 0) || (phase[u] == W + gap_of(u) + 1);
   endfunction

   // Expected {in_ready, frame, busy, done, serial_out, bit_idx} for the current cycle.
   function automatic logic [7:0] exp_vec(input int u);
      int         p;
      logic       b;
      logic [2:0] idx;
      p = phase[u];
      if (p < 0) begin
         return {4'b0000, lvl_of(u), 3'd0};
      end else if (p >= 1 && p <= W) begin
         b   = (u == 0) ? word[u][W - p] : word[u][p - 1];
         idx = 3'(p - 1);
         return {4'b0110, b, idx};
      end else if (p > W && p <= W + gap_of(u)) begin
         return {3'b001, (p == W + 1), lvl_of(u), 3'd0};
      end else begin
         return {3'b100, (p == W + 1), lvl_of(u), 3'd0};
      end
   endfunction

   // Advance the model timeline on every edge; reset parks it before idle.
   always @(posedge clk or posedge rst) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            phase[u] <= -1;
         end else if (exp_ready(u) && valid_s) begin
            phase[u] <= 1;
            word[u]  <= data_s;
         end else if (phase[u] >= 1 && phase[u] <= W + gap_of(u)) begin
            phase[u] <= phase[u] + 1;
         end else begin
            phase[u] <= 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // One cycle: check outputs on the falling edge, capture frames, then drive inputs.
   task automatic tick(input logic v, input logic [7:0] d);
      @(negedge clk);
      cyc++;
      check("u0_outputs", {24'd0, vec0}, {24'd0, exp_vec(0)});
      check("u1_outputs", {24'd0, vec1}, {24'd0, exp_vec(1)});
      if (bus0.frame) cap0 = {cap0[6:0], bus0.serial_out};
      if (bus1.frame) cap1 = {bus1.serial_out, cap1[7:1]};
      valid_s = v;
      data_s  = d;
      if (track && bus0.in_ready && v) hs0_q.push_back(cyc);
      if (track && bus1.in_ready && v) hs1_q.push_back(cyc);
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      check("u0_async_rst", {24'd0, vec0}, {24'd0, 8'b0000_0000});
      check("u1_async_rst", {24'd0, vec1}, {24'd0, 8'b0000_1000});
      tick(1'b0, 8'h00);
      tick(1'b0, 8'h00);
      rst = 1'b0;
   endtask

   task automatic send_and_check(input logic [7:0] w, input string tag);
      cap0 = 8'h00;
      cap1 = 8'h00;
      tick(1'b1, w);
      for (int i = 0; i < 16; i++) tick(1'b0, 8'($urandom));
      check({tag, "_u0"}, {24'd0, cap0}, {24'd0, w});
      check({tag, "_u1"}, {24'd0, cap1}, {24'd0, w});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
      rst = 1'b0;
      tick(1'b0, 8'h00);

      send_and_check(8'hA5, "word_a5");
      send_and_check(8'h01, "word_01");

      track = 1'b1;
      tick(1'b1, 8'hF0);
      tick(1'b1, 8'h0F);
      for (int i = 0; i < 40; i++) tick(1'b1, 8'($urandom));
      track = 1'b0;
      for (int i = 0; i < 14; i++) tick(1'b0, 8'h00);
      check("hs0_count", {31'd0, hs0_q.size() >= 4}, 32'd1);
      check("hs1_count", {31'd0, hs1_q.size() >= 5}, 32'd1);
      for (int i = 1; i < hs0_q.size(); i++) check("period_gap3", hs0_q[i] - hs0_q[i-1], 32'd12);
      for (int i = 1; i < hs1_q.size(); i++) check("period_gap0", hs1_q[i] - hs1_q[i-1], 32'd9);

      tick(1'b1, 8'hFF);
      for (int i = 0; i < 4; i++) tick(1'b0, 8'($urandom));
      async_reset();
      tick(1'b0, 8'h00);
      send_and_check(8'h81, "word_81");

      for (int i = 0; i < 800; i++) begin
         tick(($urandom_range(0, 2) != 0), 8'($urandom));
         if ($urandom_range(0, 149) == 0) async_reset();
      end
      for (int i = 0; i < 14; i++) tick(1'b0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
